// File: rtl/endian_swap_pipe.sv
// endian_swap_pipe: registered, flow-controlled byte-order swapper for the DMA
// datapath. Reverses bytes within naturally aligned elements of 2**in_swap_size
// bytes (clamped to the beat width) and permutes byte enables alongside.
// Two-entry storage (main + skid) keeps full throughput with a registered in_ready.
// Optional feature macro: SWAP_PARITY_EN adds per-byte odd parity carry and a
// sticky par_err flag.
//
// state | meaning
// EMPTY | no beat held, out_valid=0, in_ready=1
// ONE   | main holds a beat, out_valid=1, in_ready=1
// FULL  | main and skid hold beats, out_valid=1, in_ready=0
module endian_swap_pipe #(
  parameter  int BYTES = 16,
  localparam int SZW   = $clog2(BYTES) + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [0:8*BYTES-1] in_data,
  input  logic [0:BYTES-1]   in_be,
  input  logic [SZW-1:0]     in_swap_size,
`ifdef SWAP_PARITY_EN
  input  logic [0:BYTES-1]   in_par,
  output logic [0:BYTES-1]   out_par,
  output logic               par_err,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [0:8*BYTES-1] out_data,
  output logic [0:BYTES-1]   out_be
);

  localparam int             LOG2B    = $clog2(BYTES);
  localparam logic [SZW-1:0] MAX_SIZE = SZW'(LOG2B);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t             state, state_n;
  logic               accept, take;
  logic               load_main, load_skid, main_from_skid;
  logic [SZW-1:0]     eff_size;
  int                 mask;
  logic [0:8*BYTES-1] sw_data, skid_data;
  logic [0:BYTES-1]   sw_be, skid_be;

  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;
  assign take      = out_valid && out_ready;

  // Byte permutation: elements are aligned powers of two, so the source byte
  // of output byte i is simply i with its low eff_size bits inverted.
  always_comb begin
    eff_size = (in_swap_size > MAX_SIZE) ? MAX_SIZE : in_swap_size;
    mask     = (1 << eff_size) - 1;
    sw_data  = '0;
    sw_be    = '0;
    for (int i = 0; i < BYTES; i++) begin
      sw_data[8*i +: 8] = in_data[8*(i ^ mask) +: 8];
      sw_be[i]          = in_be[i ^ mask];
    end
  end

  // Next-state and storage load controls.
  always_comb begin
    state_n        = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          load_main = 1'b1;
          state_n   = ONE;
        end
      end
      ONE: begin
        if (accept && take) begin
          load_main = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_n   = FULL;
        end else if (take) begin
          state_n   = EMPTY;
        end
      end
      FULL: begin
        if (take) begin
          main_from_skid = 1'b1;
          state_n        = ONE;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= EMPTY;
    else       state <= state_n;
  end

  // in_ready is registered from the next state so it never depends on out_ready.
  always_ff @(posedge clock) begin
    if (reset) in_ready <= 1'b0;
    else       in_ready <= (state_n != FULL);
  end

  // Main and skid data/enable registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_data  <= '0;
      out_be    <= '0;
      skid_data <= '0;
      skid_be   <= '0;
    end else begin
      if (load_main) begin
        out_data <= sw_data;
        out_be   <= sw_be;
      end else if (main_from_skid) begin
        out_data <= skid_data;
        out_be   <= skid_be;
      end
      if (load_skid) begin
        skid_data <= sw_data;
        skid_be   <= sw_be;
      end
    end
  end

`ifdef SWAP_PARITY_EN
  logic [0:BYTES-1] sw_par, skid_par;
  logic             bad_par;

  // Parity bits follow their bytes; a byte is bad when data plus parity is even.
  always_comb begin
    sw_par  = '0;
    bad_par = 1'b0;
    for (int i = 0; i < BYTES; i++) begin
      sw_par[i] = in_par[i ^ mask];
      if (in_par[i] == ^in_data[8*i +: 8]) bad_par = 1'b1;
    end
  end

  // Parity storage and sticky error flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_par  <= '0;
      skid_par <= '0;
      par_err  <= 1'b0;
    end else begin
      if (load_main)           out_par  <= sw_par;
      else if (main_from_skid) out_par  <= skid_par;
      if (load_skid)           skid_par <= sw_par;
      if (accept && bad_par)   par_err  <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_endian_swap_pipe.sv
// Scoreboard bench for endian_swap_pipe (BYTES=16). The stimulus side pushes
// the expected beat when the DUT accepts it; a monitor pops and compares on
// every output transfer.
module tb_endian_swap_pipe;
  localparam int SZW = 5;

  typedef struct packed {
    logic [0:127] data;
    logic [0:15]  be;
    logic [0:15]  par;
  } beat_t;

  logic         clock, reset, in_valid, in_ready, out_valid, out_ready;
  logic [0:127] in_data, out_data;
  logic [0:15]  in_be, out_be;
  logic [SZW-1:0] in_swap_size;
`ifdef SWAP_PARITY_EN
  logic [0:15]  in_par, out_par;
  logic         par_err;
`endif

  int    n_vec = 0;
  int    n_bad = 0;
  int    last_wait = 0;
  bit    chk_ready = 0;
  bit    ready_rand = 0;
  beat_t q[$];

  localparam logic [0:127] P = 128'h000102030405060708090A0B0C0D0E0F;

  endian_swap_pipe #(.BYTES(16)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_be(in_be), .in_swap_size(in_swap_size),
`ifdef SWAP_PARITY_EN
    .in_par(in_par), .out_par(out_par), .par_err(par_err),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_be(out_be)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares", n_vec, n_bad);
    $fatal(1, "watchdog");
  end

  task automatic chk_b(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_h(input string nm, input logic [0:15] act, input logic [0:15] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_v(input string nm, input logic [0:127] act, input logic [0:127] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [0:15] good_par(input logic [0:127] d);
    logic [0:15] p;
    for (int i = 0; i < 16; i++) p[i] = ~^d[8*i +: 8];
    return p;
  endfunction

  function automatic beat_t mk(input logic [0:127] d, input logic [0:15] be);
    beat_t r;
    r.data = d;
    r.be   = be;
    r.par  = good_par(d);
    return r;
  endfunction

  // Reference permutation written straight from the element formula.
  function automatic beat_t model(input logic [0:127] d, input logic [0:15] be, input int sz);
    beat_t r;
    int    e;
    int    src;
    e = (sz > 4) ? 16 : (1 << sz);
    for (int i = 0; i < 16; i++) begin
      src = (i / e) * e + (e - 1 - (i % e));
      r.data[8*i +: 8] = d[8*src +: 8];
      r.be[i]          = be[src];
    end
    r.par = good_par(r.data);
    return r;
  endfunction

  // Present one beat and hold it until accepted; expected beat is queued on accept.
  task automatic send(input logic [0:127] d, input logic [0:15] be, input logic [SZW-1:0] sz,
                      input beat_t exp, input logic [0:15] pflip);
    int    waits;
    bit    done;
    beat_t e;
    waits = 0;
    done  = 0;
    e     = exp;
    e.par = exp.par ^ pflip;
    in_valid     = 1'b1;
    in_data      = d;
    in_be        = be;
    in_swap_size = sz;
`ifdef SWAP_PARITY_EN
    in_par = good_par(d) ^ pflip;
`endif
    while (!done) begin
      @(negedge clock);
      if (in_ready) begin
        q.push_back(e);
        done = 1;
      end else if (waits >= 200) begin
        n_vec++;
        n_bad++;
        $display("FAIL send_timeout: in_ready low for %0d cycles, required acceptance", waits);
        done = 1;
      end else begin
        waits++;
      end
      @(posedge clock);
      #1;
      if (ready_rand) out_ready = 1'($urandom_range(0, 1));
    end
    in_valid  = 1'b0;
    last_wait = waits;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((q.size() != 0 || out_valid) && n < 60) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (n >= 60) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: %0d beats still pending, required 0", q.size());
    end
  endtask

  // Monitor: scoreboard pop on each output transfer, hold-stability and in_ready checks.
  initial begin
    beat_t        e;
    bit           prev_stall;
    logic [0:127] prev_data;
    logic [0:15]  prev_be;
    prev_stall = 0;
    prev_data  = '0;
    prev_be    = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_stall = 0;
      end else begin
        if (prev_stall && out_valid) begin
          chk_v("hold_data", out_data, prev_data);
          chk_h("hold_be", out_be, prev_be);
        end
        if (chk_ready && !in_ready) chk_b("ready_low_only_full", out_valid, 1'b1);
        if (out_valid && out_ready) begin
          n_vec++;
          if (q.size() == 0) begin
            n_bad++;
            $display("FAIL spurious_beat: got %h with no beat pending", out_data);
          end else begin
            e = q.pop_front();
            if (out_data !== e.data || out_be !== e.be
`ifdef SWAP_PARITY_EN
                || out_par !== e.par
`endif
               ) begin
              n_bad++;
              $display("FAIL beat: got data %h be %h expected data %h be %h par %h",
                       out_data, out_be, e.data, e.be, e.par);
            end
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_be    = out_be;
      end
    end
  end

  initial begin
    logic [0:127] d;
    logic [0:15]  be;
    reset        = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    in_be        = '0;
    in_swap_size = '0;
    out_ready    = 1'b0;
`ifdef SWAP_PARITY_EN
    in_par = '0;
`endif
    repeat (3) @(posedge clock);
    #1;
    chk_b("rst_in_ready", in_ready, 1'b0);
    chk_b("rst_out_valid", out_valid, 1'b0);
    chk_v("rst_out_data", out_data, 128'h0);
    chk_h("rst_out_be", out_be, 16'h0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk_b("post_rst_in_ready", in_ready, 1'b1);
    chk_b("post_rst_out_valid", out_valid, 1'b0);

    // Pass-through with one-cycle latency.
    out_ready = 1'b1;
    send(P, 16'hA5C3, 5'd0, mk(P, 16'hA5C3), 16'h0);
    chk_b("t1_valid", out_valid, 1'b1);
    chk_v("t1_data", out_data, P);
    chk_h("t1_be", out_be, 16'hA5C3);

    // Back-to-back beats, each with its own element size.
    send(P, 16'hFF00, 5'd3, mk(128'h07060504030201000F0E0D0C0B0A0908, 16'hFF00), 16'h0);
    chk_i("t2_wait_s3", last_wait, 0);
    send(P, 16'hFF00, 5'd4, mk(128'h0F0E0D0C0B0A09080706050403020100, 16'h00FF), 16'h0);
    chk_i("t2_wait_s4", last_wait, 0);
    send(P, 16'hFF00, 5'd7, mk(128'h0F0E0D0C0B0A09080706050403020100, 16'h00FF), 16'h0);
    chk_i("t2_wait_s7", last_wait, 0);
    send(P, 16'h8001, 5'd1, mk(128'h01000302050407060908_0B0A0D0C0F0E, 16'h4002), 16'h0);
    send(P, 16'h1234, 5'd2, mk(128'h03020100070605040B0A09080F0E0D0C, 16'h84C2), 16'h0);
    send(128'hF0E1D2C3B4A5968778695A4B3C2D1E0F, 16'h0000, 5'd4,
         mk(128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0, 16'h0000), 16'h0);
    drain();

    // Fill to FULL, verify stall behaviour, then release with a new beat waiting.
    out_ready = 1'b0;
    send(128'h11111111111111111111111111111111, 16'hFFFF, 5'd0,
         mk(128'h11111111111111111111111111111111, 16'hFFFF), 16'h0);
    send(128'h22222222222222222222222222222222, 16'h0F0F, 5'd0,
         mk(128'h22222222222222222222222222222222, 16'h0F0F), 16'h0);
    chk_b("t4_full_in_ready", in_ready, 1'b0);
    chk_b("t4_full_valid", out_valid, 1'b1);
    chk_v("t4_full_data", out_data, 128'h11111111111111111111111111111111);
    repeat (2) @(posedge clock);
    #1;
    chk_v("t4_stall_data", out_data, 128'h11111111111111111111111111111111);
    chk_b("t4_stall_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    send(P, 16'h00F0, 5'd4, mk(128'h0F0E0D0C0B0A09080706050403020100, 16'h0F00), 16'h0);
    chk_i("t4_release_wait", last_wait, 1);
    drain();

    // Reset while FULL discards both stored beats.
    out_ready = 1'b0;
    send(128'h33333333333333333333333333333333, 16'hFFFF, 5'd0,
         mk(128'h33333333333333333333333333333333, 16'hFFFF), 16'h0);
    send(128'h44444444444444444444444444444444, 16'hFFFF, 5'd0,
         mk(128'h44444444444444444444444444444444, 16'hFFFF), 16'h0);
    reset     = 1'b1;
    out_ready = 1'b1;
    q.delete();
    @(posedge clock);
    #1;
    chk_b("t5_valid", out_valid, 1'b0);
    chk_v("t5_data", out_data, 128'h0);
    chk_h("t5_be", out_be, 16'h0);
    chk_b("t5_in_ready", in_ready, 1'b0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk_b("t5_post_in_ready", in_ready, 1'b1);
    repeat (3) begin
      @(posedge clock);
      #1;
      chk_b("t5_no_emit", out_valid, 1'b0);
    end

    // Stream 64 tagged beats under random back-pressure.
    chk_ready  = 1;
    ready_rand = 1;
    for (int k = 0; k < 64; k++) begin
      for (int j = 0; j < 16; j++) d[8*j +: 8] = 8'(k * 16 + j);
      d[0:7] = 8'(k);
      be = 16'(k * 977);
      send(d, be, 5'(k % 6), model(d, be, k % 6), 16'h0);
    end
    ready_rand = 0;
    drain();
    chk_ready = 0;
    chk_i("t3_queue_empty", q.size(), 0);

`ifdef SWAP_PARITY_EN
    // Bad parity on byte 5 of beat 3 sets a sticky error; the beat still flows.
    out_ready = 1'b1;
    chk_b("t6_err_init", par_err, 1'b0);
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 16; j++) d[8*j +: 8] = 8'(k * 37 + j * 5);
      if (k == 3) begin
        chk_b("t6_err_before", par_err, 1'b0);
        send(d, 16'hFFFF, 5'd0, mk(d, 16'hFFFF), 16'h0400);
        chk_b("t6_err_set", par_err, 1'b1);
      end else begin
        send(d, 16'hFFFF, 5'd0, mk(d, 16'hFFFF), 16'h0);
      end
    end
    drain();
    repeat (3) @(posedge clock);
    #1;
    chk_b("t6_err_sticky", par_err, 1'b1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk_b("t6_err_cleared", par_err, 1'b0);
`endif

    repeat (2) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
